dec_hl: RTL and testbench

Registered route decoder for one router of the 4x4 hierarchical-leaf (HL) mesh. It handles unicast and two-level multicast destinations.
- Unicast: selects the XY output port.
- Multicast: picks the next inter-quadrant (global) or intra-quadrant (local) branch. It splits the destination set into the copy sent now (doc_send) and the residue kept for further replication (doc_remain). It also flags the multicast table.
- Sits between the input buffer head flit and the switch allocator / multicast table.

---
 rtl/dec_hl_pkg.sv | 41 ++++
 rtl/dec_hl_if.sv | 26 ++
 rtl/hl_xy_route.sv | 25 ++
 rtl/dec_hl.sv | 139 +++++++++++++
 tb/tb_dec_hl.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/dec_hl_pkg.sv
// Shared encodings, mesh constants and field helpers for the HL route decoder.
package dec_hl_pkg;

  localparam int MESH_DIM = 4;   // nodes per mesh row/column
  localparam int QUAD_NUM = 4;   // quadrants, each a 2x2 block of leaves
  localparam int LEAF_W   = 4;   // leaf mask width per quadrant
  localparam int MASK_LSB = 16;  // quadrant mask position inside mult_dst
  localparam int MDST_W   = 20;  // total multicast destination width

  typedef enum logic [2:0] {
    PORT_LOCAL = 3'd0,
    PORT_NORTH = 3'd1,
    PORT_EAST  = 3'd2,
    PORT_SOUTH = 3'd3,
    PORT_WEST  = 3'd4
  } port_e;

  typedef enum logic [1:0] {
    UM_IDLE   = 2'd0,
    UM_GLOBAL = 2'd1,
    UM_LOCAL  = 2'd2,
    UM_EJECT  = 2'd3
  } umesh_e;

  // Everything the decoder registers, kept together so reset and capture
  // happen in one assignment.
  typedef struct packed {
    port_e             port;
    logic [MDST_W-1:0] doc_send;
    logic [MDST_W-1:0] doc_remain;
    umesh_e            umesh_state;
    logic [1:0]        multab_en;
  } dec_out_t;

  // Leaf nibble of quadrant q inside a multicast destination set.
  function automatic logic [LEAF_W-1:0] leaf_nib(input logic [MDST_W-1:0] md,
                                                 input logic [1:0]        q);
    return md[q*LEAF_W +: LEAF_W];
  endfunction

endpackage

// File: rtl/dec_hl_if.sv
// Head-flit decode bus: destination fields in, route decision out.
interface dec_hl_if;
  import dec_hl_pkg::*;

  logic              um_type;
  logic [4:0]        uni_dst;
  logic [MDST_W-1:0] mult_dst;
  logic [1:0]        src_pos;
  logic [2:0]        port;
  logic [MDST_W-1:0] doc_send;
  logic [MDST_W-1:0] doc_remain;
  logic [1:0]        umesh_state;
  logic [1:0]        multab_en;

  // Input buffer side: presents the head flit, consumes the decision.
  modport master (
    output um_type, uni_dst, mult_dst, src_pos,
    input  port, doc_send, doc_remain, umesh_state, multab_en
  );

  // Decoder side.
  modport slave (
    input  um_type, uni_dst, mult_dst, src_pos,
    output port, doc_send, doc_remain, umesh_state, multab_en
  );
endinterface

// File: rtl/hl_xy_route.sv
// Combinational XY (x first) output port from this router to a target node.
module hl_xy_route
  import dec_hl_pkg::*;
#(
  parameter int MY_XPOS = 0,
  parameter int MY_YPOS = 0
) (
  input  logic [1:0] tgt_x_i,
  input  logic [1:0] tgt_y_i,
  output port_e      port_o
);

  localparam logic [1:0] MY_X = 2'(MY_XPOS % MESH_DIM);
  localparam logic [1:0] MY_Y = 2'(MY_YPOS % MESH_DIM);

  // Resolve the row first, then the column, else the packet has arrived.
  always_comb begin
    if (tgt_x_i > MY_X)      port_o = PORT_SOUTH;
    else if (tgt_x_i < MY_X) port_o = PORT_NORTH;
    else if (tgt_y_i > MY_Y) port_o = PORT_EAST;
    else if (tgt_y_i < MY_Y) port_o = PORT_WEST;
    else                     port_o = PORT_LOCAL;
  end

endmodule

// File: rtl/dec_hl.sv
// Registered unicast / two-level multicast route decoder for one HL router.
module dec_hl
  import dec_hl_pkg::*;
#(
  parameter int MY_XPOS = 0,
  parameter int MY_YPOS = 0
) (
  input  logic     clk,
  input  logic     rst,
  dec_hl_if.slave  bus
);

  localparam logic [1:0] MY_X     = 2'(MY_XPOS);
  localparam logic [1:0] MY_Y     = 2'(MY_YPOS);
  localparam logic [1:0] MY_Q     = {MY_X[1], MY_Y[1]};
  localparam logic [1:0] OWN_LEAF = {MY_X[0], MY_Y[0]};

  logic [QUAD_NUM-1:0] eff;       // quadrants with a set mask bit and live leaves
  logic [QUAD_NUM-1:0] foreign;   // effective quadrants other than ours
  logic [MDST_W-1:0]   eff_set;   // input set with dead quadrants stripped
  logic [LEAF_W-1:0]   leaves;    // live leaves of our own quadrant
  logic [1:0]          qt;        // global target quadrant
  logic [1:0]          sel;       // chosen leaf in our quadrant
  logic [1:0]          cand;
  logic                found;
  logic                is_global;
  logic [1:0]          mc_x, mc_y;
  port_e               uni_port, mc_port;
  dec_out_t            out_d, out_q;

  // Bit 4 of the unicast destination is reserved.
  logic unused_uni_msb;
  assign unused_uni_msb = bus.uni_dst[4];

  hl_xy_route #(.MY_XPOS(MY_XPOS), .MY_YPOS(MY_YPOS)) u_uni_route (
    .tgt_x_i (bus.uni_dst[3:2]),
    .tgt_y_i (bus.uni_dst[1:0]),
    .port_o  (uni_port)
  );

  hl_xy_route #(.MY_XPOS(MY_XPOS), .MY_YPOS(MY_YPOS)) u_mc_route (
    .tgt_x_i (mc_x),
    .tgt_y_i (mc_y),
    .port_o  (mc_port)
  );

  // Pick the multicast target: next foreign quadrant after the source, else a leaf of ours.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    eff_set = '0;
    eff     = '0;
    for (int q = 0; q < QUAD_NUM; q++) begin
      eff[q] = bus.mult_dst[MASK_LSB+q] & (|leaf_nib(bus.mult_dst, 2'(q)));
      eff_set[MASK_LSB+q] = eff[q];
      if (eff[q]) eff_set[q*LEAF_W +: LEAF_W] = leaf_nib(bus.mult_dst, 2'(q));
    end
    foreign       = eff;
    foreign[MY_Q] = 1'b0;
    is_global     = |foreign;

    // Scan src+1, src+2, src+3, src; our quadrant is already masked out.
    qt    = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= QUAD_NUM; k++) begin
      cand = bus.src_pos + 2'(k);
      if (!found && foreign[cand]) begin
        qt    = cand;
        found = 1'b1;
      end
    end

    // Own leaf wins; otherwise the lowest live leaf (descending loop keeps the lowest).
    leaves = eff_set[MY_Q*LEAF_W +: LEAF_W];
    sel    = OWN_LEAF;
    if (!leaves[OWN_LEAF]) begin
      for (int l = LEAF_W - 1; l >= 0; l--) begin
        if (leaves[l]) sel = 2'(l);
      end
    end

    // Global copies go to the quadrant's representative node (even x, even y).
    if (is_global) begin
      mc_x = {qt[1], 1'b0};
      mc_y = {qt[0], 1'b0};
    end else begin
      mc_x = {MY_Q[1], sel[1]};
      mc_y = {MY_Q[0], sel[0]};
    end
  end

  // Split the effective set into the copy sent now and the residue kept here.
  always_comb begin
    logic [MDST_W-1:0] send;
    logic [MDST_W-1:0] remain;
    logic [LEAF_W-1:0] rest_leaves;
    send        = '0;
    remain      = '0;
    rest_leaves = '0;
    out_d       = '0;
    if (!bus.um_type) begin
      out_d.port = uni_port;
    end else if (is_global) begin
      send[MASK_LSB+qt]            = 1'b1;
      send[qt*LEAF_W +: LEAF_W]    = eff_set[qt*LEAF_W +: LEAF_W];
      remain                       = eff_set & ~send;
      out_d.port                   = mc_port;
      out_d.doc_send               = send;
      out_d.doc_remain             = remain;
      out_d.umesh_state            = UM_GLOBAL;
      out_d.multab_en              = {1'b0, |remain};
    end else if (eff[MY_Q]) begin
      rest_leaves                     = leaves & ~(4'b0001 << sel);
      send[MASK_LSB+MY_Q]             = 1'b1;
      send[MY_Q*LEAF_W + sel]         = 1'b1;
      remain[MY_Q*LEAF_W +: LEAF_W]   = rest_leaves;
      remain[MASK_LSB+MY_Q]           = |rest_leaves;
      out_d.port                      = mc_port;
      out_d.doc_send                  = send;
      out_d.doc_remain                = remain;
      out_d.umesh_state               = leaves[OWN_LEAF] ? UM_EJECT : UM_LOCAL;
      out_d.multab_en                 = {|remain, 1'b0};
    end
  end

  // Output register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for all clocked state avoids race-order bugs.
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign bus.port        = out_q.port;
  assign bus.doc_send    = out_q.doc_send;
  assign bus.doc_remain  = out_q.doc_remain;
  assign bus.umesh_state = out_q.umesh_state;
  assign bus.multab_en   = out_q.multab_en;

endmodule

// File: tb/tb_dec_hl.sv
// Scoreboard bench: two decoders at (0,1) and (1,0) share directed stimulus.
module tb_dec_hl;

  typedef struct {
    logic [2:0]  port;
    logic [19:0] send;
    logic [19:0] remain;
    logic [1:0]  state;
    logic [1:0]  multab;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  dec_hl_if if_a ();
  dec_hl_if if_b ();

  dec_hl #(.MY_XPOS(0), .MY_YPOS(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  dec_hl #(.MY_XPOS(1), .MY_YPOS(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  function automatic exp_t mk(input logic [2:0] p, input logic [19:0] s,
                              input logic [19:0] r, input logic [1:0] st,
                              input logic [1:0] mt);
    exp_t e;
    e.port = p; e.send = s; e.remain = r; e.state = st; e.multab = mt;
    return e;
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare(input string tag, input exp_t e, input logic [2:0] p,
                         input logic [19:0] s, input logic [19:0] r,
                         input logic [1:0] st, input logic [1:0] mt);
    check({tag, ".port"},        20'(p),  20'(e.port));
    check({tag, ".doc_send"},    s,       e.send);
    check({tag, ".doc_remain"},  r,       e.remain);
    check({tag, ".umesh_state"}, 20'(st), 20'(e.state));
    check({tag, ".multab_en"},   20'(mt), 20'(e.multab));
  endtask

  // Drive one cycle of inputs on the falling edge and record what each DUT owes.
  task automatic apply(input logic r, input logic um, input logic [4:0] ud,
                       input logic [19:0] md, input logic [1:0] sp,
                       input exp_t ea, input exp_t eb);
    @(negedge clk);
    rst = r;
    if_a.um_type = um; if_a.uni_dst = ud; if_a.mult_dst = md; if_a.src_pos = sp;
    if_b.um_type = um; if_b.uni_dst = ud; if_b.mult_dst = md; if_b.src_pos = sp;
    qa.push_back(ea);
    qb.push_back(eb);
  endtask

  // Monitor: registered outputs settle after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        compare("a", e, if_a.port, if_a.doc_send, if_a.doc_remain, if_a.umesh_state, if_a.multab_en);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        compare("b", e, if_b.port, if_b.doc_send, if_b.doc_remain, if_b.umesh_state, if_b.multab_en);
      end
    end
  end

  initial begin
    exp_t z;
    z = mk(3'd0, 20'h0, 20'h0, 2'd0, 2'd0);
    if_a.um_type = 1'b0; if_a.uni_dst = '0; if_a.mult_dst = '0; if_a.src_pos = '0;
    if_b.um_type = 1'b0; if_b.uni_dst = '0; if_b.mult_dst = '0; if_b.src_pos = '0;

    // Reset with random inputs
    repeat (2) apply(1'b1, 1'($urandom), 5'($urandom), 20'($urandom), 2'($urandom), z, z);

    // Unicast (mult_dst content must not leak into the multicast outputs)
    apply(0, 0, 5'd7,  20'hABCDE, 2'd1, mk(3'd3, 0, 0, 0, 0), mk(3'd2, 0, 0, 0, 0));
    apply(0, 0, 5'd1,  20'hFFFFF, 2'd0, mk(3'd0, 0, 0, 0, 0), mk(3'd1, 0, 0, 0, 0));
    apply(0, 0, 5'h11, 20'h0,     2'd0, mk(3'd0, 0, 0, 0, 0), mk(3'd1, 0, 0, 0, 0));
    apply(0, 0, 5'd4,  20'h12345, 2'd2, mk(3'd3, 0, 0, 0, 0), mk(3'd0, 0, 0, 0, 0));
    apply(0, 0, 5'd0,  20'h0,     2'd3, mk(3'd4, 0, 0, 0, 0), mk(3'd1, 0, 0, 0, 0));

    // Global, single foreign quadrant
    apply(0, 1, 5'd0, 20'b0100_0000_0001_0000_0000, 2'd0,
          mk(3'd3, 20'b0100_0000_0001_0000_0000, 20'h0, 2'd1, 2'b00),
          mk(3'd3, 20'b0100_0000_0001_0000_0000, 20'h0, 2'd1, 2'b00));
    // Global, scan 2,3,0,1 picks quadrant 3
    apply(0, 1, 5'd0, 20'b1010_0001_0000_0001_0000, 2'd1,
          mk(3'd3, 20'b1000_0001_0000_0000_0000, 20'b0010_0000_0000_0001_0000, 2'd1, 2'b01),
          mk(3'd3, 20'b1000_0001_0000_0000_0000, 20'b0010_0000_0000_0001_0000, 2'd1, 2'b01));
    // Global, scan wraps 3,0,1,2 -> quadrant 3
    apply(0, 1, 5'd0, 20'b1010_0001_0000_0010_0000, 2'd2,
          mk(3'd3, 20'b1000_0001_0000_0000_0000, 20'b0010_0000_0000_0010_0000, 2'd1, 2'b01),
          mk(3'd3, 20'b1000_0001_0000_0000_0000, 20'b0010_0000_0000_0010_0000, 2'd1, 2'b01));
    // Same set, src 0 -> quadrant 1 first
    apply(0, 1, 5'd0, 20'b1010_0001_0000_0010_0000, 2'd0,
          mk(3'd2, 20'b0010_0000_0000_0010_0000, 20'b1000_0001_0000_0000_0000, 2'd1, 2'b01),
          mk(3'd1, 20'b0010_0000_0000_0010_0000, 20'b1000_0001_0000_0000_0000, 2'd1, 2'b01));
    // Own quadrant plus foreign: foreign goes first, own kept as residue
    apply(0, 1, 5'd0, 20'b0011_0000_0000_1000_0010, 2'd3,
          mk(3'd2, 20'b0010_0000_0000_1000_0000, 20'b0001_0000_0000_0000_0010, 2'd1, 2'b01),
          mk(3'd1, 20'b0010_0000_0000_1000_0000, 20'b0001_0000_0000_0000_0010, 2'd1, 2'b01));

    // Local phase
    apply(0, 1, 5'd0, 20'b0001_0000_0000_0000_0110, 2'd0,
          mk(3'd0, 20'b0001_0000_0000_0000_0010, 20'b0001_0000_0000_0000_0100, 2'd3, 2'b10),
          mk(3'd0, 20'b0001_0000_0000_0000_0100, 20'b0001_0000_0000_0000_0010, 2'd3, 2'b10));
    apply(0, 1, 5'd0, 20'b0001_0000_0000_0000_1100, 2'd1,
          mk(3'd3, 20'b0001_0000_0000_0000_0100, 20'b0001_0000_0000_0000_1000, 2'd2, 2'b10),
          mk(3'd0, 20'b0001_0000_0000_0000_0100, 20'b0001_0000_0000_0000_1000, 2'd3, 2'b10));
    apply(0, 1, 5'd0, 20'b0001_0000_0000_0000_0010, 2'd2,
          mk(3'd0, 20'b0001_0000_0000_0000_0010, 20'h0, 2'd3, 2'b00),
          mk(3'd1, 20'b0001_0000_0000_0000_0010, 20'h0, 2'd2, 2'b00));
    // Unmasked nibble must be ignored
    apply(0, 1, 5'd0, 20'b0001_0000_0101_0000_0010, 2'd0,
          mk(3'd0, 20'b0001_0000_0000_0000_0010, 20'h0, 2'd3, 2'b00),
          mk(3'd1, 20'b0001_0000_0000_0000_0010, 20'h0, 2'd2, 2'b00));

    // Empty effective sets
    apply(0, 1, 5'd0, 20'b0010_0000_0000_0000_0000, 2'd0, z, z);
    apply(0, 1, 5'd0, 20'h0, 2'd0, z, z);

    // Reset after a busy cycle clears everything
    apply(0, 1, 5'd0, 20'b1010_0001_0000_0001_0000, 2'd1,
          mk(3'd3, 20'b1000_0001_0000_0000_0000, 20'b0010_0000_0000_0001_0000, 2'd1, 2'b01),
          mk(3'd3, 20'b1000_0001_0000_0000_0000, 20'b0010_0000_0000_0001_0000, 2'd1, 2'b01));
    apply(1, 1, 5'd0, 20'b1010_0001_0000_0001_0000, 2'd1, z, z);
    apply(0, 0, 5'd7, 20'h0, 2'd0, mk(3'd3, 0, 0, 0, 0), mk(3'd2, 0, 0, 0, 0));

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++) @(posedge clk);
    #3;
    n_tests++;
    if (qa.size() > 0 || qb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
